// File: rtl/fifo_wr_packer.sv
// Splits a 2*DATA_WIDTH producer word into one or two FIFO writes.
// A one-entry buffer plus a three-state sequencer gives single-word-per-cycle throughput.
module fifo_wr_packer #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                    wclk,
    input  logic                    wrst,
    input  logic [2*DATA_WIDTH-1:0] in_data,
    input  logic                    in_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    wfull,
    output logic                    winc,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic                    busy,
    output logic [15:0]             wr_count
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SEND_FIRST  = 2'd1,
        SEND_SECOND = 2'd2
    } state_t;

    state_t                    state_q;
    state_t                    state_d;
    logic [2*DATA_WIDTH-1:0]   buf_q;
    logic [2*DATA_WIDTH-1:0]   buf_d;
    logic                      len_q;
    logic                      len_d;
    logic [15:0]               wr_count_q;
    logic [15:0]               wr_count_d;

    logic                      winc_s;
    logic                      last_byte_s;
    logic                      in_ready_s;
    logic                      accept_s;
    logic [DATA_WIDTH-1:0]     wdata_s;
    logic [DATA_WIDTH-1:0]     lo_half_s;
    logic [DATA_WIDTH-1:0]     hi_half_s;

    assign lo_half_s = buf_q[DATA_WIDTH-1:0];
    assign hi_half_s = buf_q[2*DATA_WIDTH-1:DATA_WIDTH];

    // Handshake and write strobe; a slot frees up when the last byte leaves this cycle.
    always_comb begin
        winc_s      = 1'b0;
        last_byte_s = 1'b0;
        if (state_q != IDLE) begin
            winc_s = ~wfull;
        end else begin
            winc_s = 1'b0;
        end
        if ((state_q == SEND_SECOND) || ((state_q == SEND_FIRST) && !len_q)) begin
            last_byte_s = 1'b1;
        end else begin
            last_byte_s = 1'b0;
        end
        in_ready_s = (state_q == IDLE) || (last_byte_s && winc_s);
        accept_s   = in_valid && in_ready_s;
    end

    // Byte select: single-word transfers always use the low half.
    always_comb begin
        wdata_s = {DATA_WIDTH{1'b0}};
        case (state_q)
            SEND_FIRST: begin
                if (MSB_FIRST && len_q) begin
                    wdata_s = hi_half_s;
                end else begin
                    wdata_s = lo_half_s;
                end
            end
            SEND_SECOND: begin
                if (MSB_FIRST) begin
                    wdata_s = lo_half_s;
                end else begin
                    wdata_s = hi_half_s;
                end
            end
            default: wdata_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    // Next-state logic; everything holds while the FIFO reports full.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        len_d      = len_q;
        wr_count_d = wr_count_q;
        if (winc_s) begin
            wr_count_d = wr_count_q + 16'd1;
        end else begin
            wr_count_d = wr_count_q;
        end
        if (accept_s) begin
            buf_d = in_data;
            len_d = in_len;
        end else begin
            buf_d = buf_q;
            len_d = len_q;
        end
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = SEND_FIRST;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND_FIRST: begin
                if (!winc_s) begin
                    state_d = SEND_FIRST;
                end else if (len_q) begin
                    state_d = SEND_SECOND;
                end else if (accept_s) begin
                    state_d = SEND_FIRST;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND_SECOND: begin
                if (!winc_s) begin
                    state_d = SEND_SECOND;
                end else if (accept_s) begin
                    state_d = SEND_FIRST;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, buffer and write counter registers.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q    <= IDLE;
            buf_q      <= {(2*DATA_WIDTH){1'b0}};
            len_q      <= 1'b0;
            wr_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            len_q      <= len_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign winc     = winc_s;
    assign wdata    = wdata_s;
    assign in_ready = in_ready_s;
    assign busy     = (state_q != IDLE);
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Directed bench for fifo_wr_packer: LSB-first and MSB-first instances share clock and reset.
module tb_fifo_wr_packer;

    logic        wclk = 1'b0;
    logic        wrst = 1'b1;

    logic [15:0] in_data0 = 16'h0000;
    logic        in_len0 = 1'b0;
    logic        in_valid0 = 1'b0;
    logic        wfull0 = 1'b0;
    logic        in_ready0, winc0, busy0;
    logic [7:0]  wdata0;
    logic [15:0] wr_count0;

    logic [15:0] in_data1 = 16'h0000;
    logic        in_len1 = 1'b0;
    logic        in_valid1 = 1'b0;
    logic        wfull1 = 1'b0;
    logic        in_ready1, winc1, busy1;
    logic [7:0]  wdata1;
    logic [15:0] wr_count1;

    int checks = 0;
    int failures = 0;

    always #5 wclk = ~wclk;

    fifo_wr_packer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut0 (
        .wclk(wclk), .wrst(wrst), .in_data(in_data0), .in_len(in_len0),
        .in_valid(in_valid0), .in_ready(in_ready0), .wfull(wfull0),
        .winc(winc0), .wdata(wdata0), .busy(busy0), .wr_count(wr_count0)
    );

    fifo_wr_packer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut1 (
        .wclk(wclk), .wrst(wrst), .in_data(in_data1), .in_len(in_len1),
        .in_valid(in_valid1), .in_ready(in_ready1), .wfull(wfull1),
        .winc(winc1), .wdata(wdata1), .busy(busy1), .wr_count(wr_count1)
    );

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp);
        end
    endtask

    // Advance to the next falling edge, then let combinational outputs settle.
    task automatic step();
        @(negedge wclk);
        #1;
    endtask

    initial begin
        int n;
        // Reset values while wrst is held high
        #2;
        chk("rst_winc", {15'd0, winc0}, 16'd0);
        chk("rst_busy", {15'd0, busy0}, 16'd0);
        chk("rst_ready", {15'd0, in_ready0}, 16'd1);
        chk("rst_wdata", {8'd0, wdata0}, 16'h0000);
        chk("rst_count", wr_count0, 16'd0);

        // Two-word LSB-first transfer, accepted on the first edge after reset release
        @(negedge wclk);
        wrst = 1'b0;
        in_valid0 = 1'b1; in_data0 = 16'hA55A; in_len0 = 1'b1;
        #1;
        chk("a55a_ready", {15'd0, in_ready0}, 16'd1);
        step();
        in_valid0 = 1'b0; in_data0 = 16'hFFFF;
        chk("a55a_winc1", {15'd0, winc0}, 16'd1);
        chk("a55a_w1", {8'd0, wdata0}, 16'h005A);
        chk("a55a_busy1", {15'd0, busy0}, 16'd1);
        chk("a55a_ready1", {15'd0, in_ready0}, 16'd0);
        step();
        chk("a55a_winc2", {15'd0, winc0}, 16'd1);
        chk("a55a_w2", {8'd0, wdata0}, 16'h00A5);
        chk("a55a_cnt1", wr_count0, 16'd1);
        step();
        chk("a55a_winc3", {15'd0, winc0}, 16'd0);
        chk("a55a_busy3", {15'd0, busy0}, 16'd0);
        chk("a55a_cnt2", wr_count0, 16'd2);

        // Back-to-back: 0x0033 (len 0) then 0x1234 (len 1)
        in_valid0 = 1'b1; in_data0 = 16'h0033; in_len0 = 1'b0;
        step();
        chk("b2b_w1", {8'd0, wdata0}, 16'h0033);
        chk("b2b_winc1", {15'd0, winc0}, 16'd1);
        chk("b2b_ready1", {15'd0, in_ready0}, 16'd1);
        in_data0 = 16'h1234; in_len0 = 1'b1;
        step();
        in_valid0 = 1'b0;
        #1;
        chk("b2b_w2", {8'd0, wdata0}, 16'h0034);
        chk("b2b_ready2", {15'd0, in_ready0}, 16'd0);
        step();
        chk("b2b_w3", {8'd0, wdata0}, 16'h0012);
        chk("b2b_ready3", {15'd0, in_ready0}, 16'd1);
        step();
        chk("b2b_idle", {15'd0, busy0}, 16'd0);
        chk("b2b_cnt", wr_count0, 16'd5);

        // Backpressure: accept 0xBEEF, hold wfull for 5 cycles with junk offered
        in_valid0 = 1'b1; in_data0 = 16'hBEEF; in_len0 = 1'b1; wfull0 = 1'b1;
        step();
        in_data0 = 16'h7777; in_len0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("full_winc", {15'd0, winc0}, 16'd0);
            chk("full_wdata", {8'd0, wdata0}, 16'h00EF);
            if (i < 4) step();
        end
        in_valid0 = 1'b0; wfull0 = 1'b0;
        #1;
        chk("full_rel_winc", {15'd0, winc0}, 16'd1);
        chk("full_rel_w1", {8'd0, wdata0}, 16'h00EF);
        step();
        chk("full_rel_w2", {8'd0, wdata0}, 16'h00BE);
        chk("full_rel_cnt", wr_count0, 16'd6);
        step();
        chk("full_done", {15'd0, winc0}, 16'd0);
        chk("full_cnt", wr_count0, 16'd7);

        // MSB-first instance
        in_valid1 = 1'b1; in_data1 = 16'hBEEF; in_len1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        chk("msb_w1", {8'd0, wdata1}, 16'h00BE);
        step();
        chk("msb_w2", {8'd0, wdata1}, 16'h00EF);
        in_valid1 = 1'b1; in_data1 = 16'h00C3; in_len1 = 1'b0;
        step();
        in_valid1 = 1'b0;
        chk("msb_len0", {8'd0, wdata1}, 16'h00C3);
        chk("msb_len0_winc", {15'd0, winc1}, 16'd1);
        step();
        chk("msb_idle", {15'd0, busy1}, 16'd0);
        chk("msb_cnt", wr_count1, 16'd3);

        // Reset pulse in SEND_SECOND discards the pending byte
        in_valid0 = 1'b1; in_data0 = 16'h1111; in_len0 = 1'b1;
        step();
        in_valid0 = 1'b0;
        step();
        chk("mid_pre_w", {8'd0, wdata0}, 16'h0011);
        wrst = 1'b1;
        #1;
        chk("mid_rst_winc", {15'd0, winc0}, 16'd0);
        chk("mid_rst_cnt", wr_count0, 16'd0);
        chk("mid_rst_busy", {15'd0, busy0}, 16'd0);
        @(negedge wclk);
        wrst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_winc", {15'd0, winc0}, 16'd0);
        end
        chk("post_rst_cnt", wr_count0, 16'd0);

        // Streaming to the 16-bit counter wrap
        in_valid0 = 1'b1; in_data0 = 16'h00FF; in_len0 = 1'b1;
        n = 0;
        while ((wr_count0 !== 16'hFFFF) && (n < 70000)) begin
            step();
            n++;
        end
        chk("wrap_reached", wr_count0, 16'hFFFF);
        chk("wrap_winc", {15'd0, winc0}, 16'd1);
        step();
        chk("wrap_zero", wr_count0, 16'd0);
        in_valid0 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_packer.md
FIFO_WR_PACKER -- requirements
Module: fifo_wr_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: FIFO word width; input word is 2*DATA_WIDTH bits.
REQ-002 Parameter MSB_FIRST, default 0: 0 sends the low byte first, 1 sends the high byte first.
REQ-003 wclk  input  1  write-domain clock; all state updates on its rising edge.
REQ-004 wrst  input  1  asynchronous, active-high reset.
REQ-005 in_data  input  2*DATA_WIDTH  result word from the producer, such as an ALU result or register read.
REQ-006 in_len  input  1  0 = one FIFO word (low half only), 1 = two FIFO words.
REQ-007 in_valid  input  1  producer offers in_data/in_len this cycle.
REQ-008 in_ready  output  1  block accepts the offer this cycle.
REQ-009 wfull  input  1  registered full flag from the FIFO write-pointer stage.
REQ-010 winc  output  1  FIFO write strobe; one FIFO word is written per cycle in which it is high.
REQ-011 wdata  output  DATA_WIDTH  FIFO write data; valid whenever winc is high.
REQ-012 busy  output  1  high while any accepted byte is not yet written.
REQ-013 wr_count  output  16  total FIFO words written since reset; wraps at 65535 -> 0.

Function
REQ-014 States SHALL be IDLE, SEND_FIRST and SEND_SECOND; busy SHALL be high in any state other than IDLE.
REQ-015 An accept SHALL occur on an edge where in_valid and in_ready are both high; it latches in_data and in_len into an internal buffer and moves to SEND_FIRST.
REQ-016 in_ready SHALL be high in IDLE, and also in the last-byte state when winc is high that cycle (back-to-back accept).
REQ-017 In SEND_FIRST, wdata SHALL be buf[DATA_WIDTH-1:0], or the high half when MSB_FIRST=1 and len=1.
REQ-018 In SEND_SECOND, wdata SHALL be the remaining half.
REQ-019 For len=0, the byte sent SHALL always be the low half, regardless of MSB_FIRST.
REQ-020 winc SHALL equal (state != IDLE) && !wfull, combinationally; winc SHALL never be high while wfull is high.
REQ-021 On a winc edge in SEND_FIRST: if len=1, go to SEND_SECOND; otherwise go to IDLE, or to SEND_FIRST if a back-to-back accept occurs that edge.
REQ-022 On a winc edge in SEND_SECOND: go to IDLE, or to SEND_FIRST if a back-to-back accept occurs that edge.
REQ-023 While wfull is high, state, buffer and wdata SHALL hold; no byte SHALL be skipped or duplicated.
REQ-024 Latency SHALL be one cycle: an accept at edge N drives winc high in cycle N+1 if wfull is low.
REQ-025 Sustained throughput with wfull low SHALL be one FIFO word per cycle.
REQ-026 wr_count SHALL increment by 1 on every edge with winc high, modulo 2^16.
REQ-027 in_data and in_len changes while in_ready is low SHALL have no effect.

Reset
REQ-028 While wrst is high: state=IDLE, buffer=0, len=0, wr_count=0, winc=0, busy=0, in_ready=1, wdata=0.
REQ-029 Reset assertion SHALL take effect immediately, without waiting for wclk.
REQ-030 Reset asserted mid-transfer SHALL discard untransmitted bytes; no winc pulse SHALL follow the deassertion until a new accept.
REQ-031 The first accept SHALL be possible on the first wclk edge after wrst deasserts.

Verification
REQ-032 MSB_FIRST=0, wfull=0, accept 0xA55A with len=1 -> winc for 2 cycles, wdata 0x5A then 0xA5, wr_count=2, busy falls after the second write.
REQ-033 Accept 0x0033 with len=0 and 0x1234 with len=1 back-to-back, wfull=0 -> wdata 0x33, 0x34, 0x12 on 3 consecutive cycles, in_ready high on the 1st and 3rd of these cycles.
REQ-034 Accept 0xBEEF with len=1 and hold wfull=1 for 5 cycles -> winc=0 and wdata=0xEF held throughout; after wfull falls, 0xEF then 0xBE are written once each.
REQ-035 MSB_FIRST=1, accept 0xBEEF with len=1 -> wdata 0xBE then 0xEF; accept 0x00C3 with len=0 -> 0xC3.
REQ-036 Pulse wrst in SEND_SECOND -> winc=0 immediately, wr_count=0, no further writes until the next accept.
REQ-037 Preload wr_count to 65535 through writes, then write one more word -> wr_count=0.
